alu_exec: RTL and testbench

//   Execution-stage ALU that consumes the Operation code from ALU control and computes the result.

---
 rtl/alu_exec_pkg.sv | 34 +++
 rtl/alu_muldiv_seq.sv | 100 ++++++++++
 rtl/alu_exec.sv | 103 ++++++++++
 tb/tb_alu_exec.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared ALU constants: operation codes, widths and the MULT/DIV sequencer states.
package alu_exec_pkg;

  localparam int DATA_W   = 32;
  localparam int OP_SIZE  = 4;
  localparam int MD_ITERS = 32;

  localparam logic [OP_SIZE-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_SIZE-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_SIZE-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_SIZE-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_SIZE-1:0] ALU_NOR  = 4'd4;
  localparam logic [OP_SIZE-1:0] ALU_SLT  = 4'd5;
  localparam logic [OP_SIZE-1:0] ALU_SLL  = 4'd6;
  localparam logic [OP_SIZE-1:0] ALU_SRL  = 4'd7;
  localparam logic [OP_SIZE-1:0] ALU_LUI  = 4'd8;
  localparam logic [OP_SIZE-1:0] ALU_BEQ  = 4'd9;
  localparam logic [OP_SIZE-1:0] ALU_BGEZ = 4'd10;
  localparam logic [OP_SIZE-1:0] ALU_MFHI = 4'd11;
  localparam logic [OP_SIZE-1:0] ALU_MFLO = 4'd12;
  localparam logic [OP_SIZE-1:0] ALU_MULT = 4'd13;
  localparam logic [OP_SIZE-1:0] ALU_DIV  = 4'd14;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_ITER  = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed MULT/DIV on unsigned magnitudes, one bit per cycle; owns HI/LO.
//   state    | meaning
//   MD_IDLE  | waiting for start; magnitudes and signs latched on start
//   MD_ITER  | 32 shift-add / restoring-divide steps, cnt 31..0
//   MD_FIXUP | apply signs, write HI/LO, raise done
module alu_muldiv_seq
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e               state, state_nx;
  logic [4:0]              cnt;
  logic [2*DATA_W-1:0]     acc;
  logic [DATA_W-1:0]       m;
  logic                    div_q, sign_q, sign_a, b_zero;

  logic [DATA_W:0]         mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0]     mstep, dstep;

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE:  if (start) state_nx = MD_ITER;
      MD_ITER:  if (cnt == 5'd0) state_nx = MD_FIXUP;
      MD_FIXUP: state_nx = MD_IDLE;
      default:  state_nx = MD_IDLE;
    endcase
  end

  // acc holds {partial product} for MULT and {remainder, shifting dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, m} : '0);
    mstep     = {mul_sum, acc[DATA_W-1:1]};
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff  = div_shift - {1'b0, m};
    dstep     = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                 : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      div_q  <= 1'b0;
      sign_q <= 1'b0;
      sign_a <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: if (start) begin
          div_q  <= is_div;
          sign_q <= a[DATA_W-1] ^ b[DATA_W-1];
          sign_a <= a[DATA_W-1];
          b_zero <= (b == '0);
          m      <= is_div ? mag(b) : mag(a);
          acc    <= {{DATA_W{1'b0}}, (is_div ? mag(a) : mag(b))};
          cnt    <= 5'(MD_ITERS - 1);
        end
        MD_ITER: begin
          acc <= div_q ? dstep : mstep;
          cnt <= cnt - 5'd1;
        end
        MD_FIXUP: begin
          if (div_q) begin
            hi <= sign_a ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            lo <= b_zero ? '1 : (sign_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
          end else begin
            {hi, lo} <= sign_q ? -acc : acc;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // stays high through the done cycle so it falls together with result_valid
  assign busy = (state != MD_IDLE) || done;

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU: registered single-cycle datapath plus the MULT/DIV sequencer.
// ALU_OVERFLOW_EN enables registered signed-overflow detection on ADD/SUB.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [OP_SIZE-1:0] Operation,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [4:0]         shamt,
  output logic [DATA_W-1:0]  Result,
  output logic               Zero,
  output logic               Overflow,
  output logic               result_valid,
  output logic               busy
);

  logic [DATA_W-1:0] sum, diff, res, md_hi, md_lo;
  logic              zero, is_md, accept, md_done;

  assign is_md  = (Operation == ALU_MULT) || (Operation == ALU_DIV);
  assign accept = op_valid && !busy;

  alu_muldiv_seq u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_md),
    .is_div (Operation == ALU_DIV),
    .a      (A),
    .b      (B),
    .busy   (busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    sum  = A + B;
    diff = A - B;
    res  = '0;
    case (Operation)
      ALU_ADD:  res = sum;
      ALU_SUB:  res = diff;
      ALU_AND:  res = A & B;
      ALU_OR:   res = A | B;
      ALU_NOR:  res = ~(A | B);
      ALU_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL:  res = B << shamt;
      ALU_SRL:  res = B >> shamt;
      ALU_LUI:  res = {B[15:0], 16'h0};
      ALU_MFHI: res = md_hi;
      ALU_MFLO: res = md_lo;
      default:  res = '0;
    endcase
    case (Operation)
      ALU_BEQ:  zero = (A == B);
      ALU_BGEZ: zero = !A[DATA_W-1];
      default:  zero = (res == '0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Result       <= '0;
      Zero         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (md_done) begin
        Result       <= md_lo;
        Zero         <= (md_lo == '0);
        result_valid <= 1'b1;
      end else if (accept && !is_md) begin
        Result       <= res;
        Zero         <= zero;
        result_valid <= 1'b1;
      end
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    if (Operation == ALU_ADD)
      ovf = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
    else if (Operation == ALU_SUB)
      ovf = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst)                      Overflow <= 1'b0;
    else if (md_done)             Overflow <= 1'b0;
    else if (accept && !is_md)    Overflow <= ovf;
  end
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; expected values are hand-computed.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               op_valid = 1'b0;
  logic [OP_SIZE-1:0] Operation = '0;
  logic [31:0]        A = '0, B = '0;
  logic [4:0]         shamt = '0;
  logic [31:0]        Result;
  logic               Zero, Overflow, result_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .Operation(Operation),
    .A(A), .B(B), .shamt(shamt), .Result(Result), .Zero(Zero),
    .Overflow(Overflow), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // drive one op for one edge; outputs are sampled 1 time unit after that edge
  task automatic issue(input logic [OP_SIZE-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    op_valid = 1'b1; Operation = op; A = a; B = b; shamt = sh;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // waits for result_valid (bounded), injecting one ignored op while busy
  task automatic wait_done(output int n);
    n = 0;
    while (!result_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        op_valid = 1'b1; Operation = ALU_ADD; A = 32'd1; B = 32'd1;
      end else if (n == 6) begin
        op_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({Result, Zero, Overflow, result_valid, busy} !== 36'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", {Result, Zero, Overflow, result_valid, busy});
      n_fail++;
    end
    n_checks++;
    rst = 1'b0;
    issue(ALU_MFHI, 0, 0, 0);
    if (Result !== 32'd0 || result_valid !== 1'b1) begin
      $display("FAIL reset_hi: got %h v=%b expected 0 v=1", Result, result_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_arith;
    issue(ALU_ADD, 7, 5, 0);
    if (Result !== 32'd12 || Zero !== 1'b0 || result_valid !== 1'b1) begin
      $display("FAIL add: got %h z=%b v=%b expected c z=0 v=1", Result, Zero, result_valid); n_fail++;
    end
    n_checks++;
    issue(ALU_SUB, 5, 5, 0);
    if (Result !== 32'd0 || Zero !== 1'b1) begin
      $display("FAIL sub: got %h z=%b expected 0 z=1", Result, Zero); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (result_valid !== 1'b0) begin
      $display("FAIL valid_pulse: got %b expected 0", result_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_logic_shift;
    logic [OP_SIZE-1:0] ops [8] = '{ALU_SLT, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI, ALU_AND, ALU_OR, ALU_NOR};
    logic [31:0] av [8] = '{32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'h0000_F0F0, 32'h0000_F0F0, 0};
    logic [31:0] bv [8] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h1234, 32'h0000_FF00, 32'h0000_FF00, 0};
    logic [4:0]  sv [8] = '{0, 0, 31, 31, 0, 0, 0, 0};
    logic [31:0] ev [8] = '{32'd1, 32'd0, 32'h8000_0000, 32'd1, 32'h1234_0000, 32'h0000_F000, 32'h0000_FFF0, 32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], av[i], bv[i], sv[i]);
      if (Result !== ev[i] || Zero !== (ev[i] == 0) || result_valid !== 1'b1) begin
        $display("FAIL logic_shift[%0d]: got %h z=%b v=%b expected %h", i, Result, Zero, result_valid, ev[i]);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_mult;
    int n;
    issue(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      $display("FAIL mult_busy: got busy=%b v=%b expected 1 0", busy, result_valid); n_fail++;
    end
    n_checks++;
    wait_done(n);
    if (n !== 34 || busy !== 1'b0 || Result !== 32'hFFFF_FFEB) begin
      $display("FAIL mult_latency: got n=%0d busy=%b res=%h expected 34 0 ffffffeb", n, busy, Result); n_fail++;
    end
    n_checks++;
    issue(ALU_MFHI, 0, 0, 0);
    if (Result !== 32'hFFFF_FFFF) begin
      $display("FAIL mult_hi: got %h expected ffffffff", Result); n_fail++;
    end
    n_checks++;
    issue(ALU_MFLO, 0, 0, 0);
    if (Result !== 32'hFFFF_FFEB) begin
      $display("FAIL mult_lo: got %h expected ffffffeb", Result); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_div;
    logic [31:0] av [3] = '{32'hFFFF_FFEF, 32'd9, 32'h8000_0000};
    logic [31:0] bv [3] = '{32'd5, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] eh [3] = '{32'hFFFF_FFFE, 32'd9, 32'd0};
    logic [31:0] el [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(ALU_DIV, av[i], bv[i], 0);
      wait_done(n);
      if (n !== 34 || Result !== el[i]) begin
        $display("FAIL div_lat[%0d]: got n=%0d res=%h expected 34 %h", i, n, Result, el[i]); n_fail++;
      end
      n_checks++;
      issue(ALU_MFHI, 0, 0, 0);
      if (Result !== eh[i]) begin
        $display("FAIL div_hi[%0d]: got %h expected %h", i, Result, eh[i]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_branch_ovf;
    issue(ALU_BEQ, 32'h55, 32'h55, 0);
    if (Zero !== 1'b1) begin
      $display("FAIL beq: got %b expected 1", Zero); n_fail++;
    end
    n_checks++;
    issue(ALU_BGEZ, 32'h8000_0000, 0, 0);
    if (Zero !== 1'b0) begin
      $display("FAIL bgez_neg: got %b expected 0", Zero); n_fail++;
    end
    n_checks++;
    issue(ALU_BGEZ, 32'h7FFF_FFFF, 0, 0);
    if (Zero !== 1'b1) begin
      $display("FAIL bgez_pos: got %b expected 1", Zero); n_fail++;
    end
    n_checks++;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0);
`ifdef ALU_OVERFLOW_EN
    if (Result !== 32'h8000_0000 || Overflow !== 1'b1) begin
      $display("FAIL add_ovf: got %h o=%b expected 80000000 o=1", Result, Overflow); n_fail++;
    end
    n_checks++;
    issue(ALU_SUB, 32'h8000_0000, 32'd1, 0);
    if (Result !== 32'h7FFF_FFFF || Overflow !== 1'b1) begin
      $display("FAIL sub_ovf: got %h o=%b expected 7fffffff o=1", Result, Overflow); n_fail++;
    end
    n_checks++;
`else
    if (Result !== 32'h8000_0000 || Overflow !== 1'b0) begin
      $display("FAIL add_ovf: got %h o=%b expected 80000000 o=0", Result, Overflow); n_fail++;
    end
    n_checks++;
`endif
    issue(4'hF, 5, 5, 0);
    if (Result !== 32'd0 || Zero !== 1'b1 || result_valid !== 1'b1) begin
      $display("FAIL unknown_op: got %h z=%b v=%b expected 0 1 1", Result, Zero, result_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back;
    issue(ALU_ADD, 32'd100, 32'd23, 0);
    if (Result !== 32'd123 || result_valid !== 1'b1) begin
      $display("FAIL b2b_first: got %h v=%b expected 7b 1", Result, result_valid); n_fail++;
    end
    n_checks++;
    op_valid = 1'b1; Operation = ALU_OR; A = 32'hA0; B = 32'h0B;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (Result !== 32'hAB || result_valid !== 1'b1) begin
      $display("FAIL b2b_second: got %h v=%b expected ab 1", Result, result_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_op;
    int seen = 0;
    issue(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      $display("FAIL abort_busy: got busy=%b v=%b expected 0 0", busy, result_valid); n_fail++;
    end
    n_checks++;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) seen++;
    end
    if (seen !== 0) begin
      $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); n_fail++;
    end
    n_checks++;
    issue(ALU_MFHI, 0, 0, 0);
    if (Result !== 32'd0) begin
      $display("FAIL abort_hi: got %h expected 0", Result); n_fail++;
    end
    n_checks++;
    issue(ALU_MFLO, 0, 0, 0);
    if (Result !== 32'd0) begin
      $display("FAIL abort_lo: got %h expected 0", Result); n_fail++;
    end
    n_checks++;
    issue(ALU_ADD, 1, 1, 0);
    if (Result !== 32'd2 || result_valid !== 1'b1) begin
      $display("FAIL abort_add: got %h v=%b expected 2 1", Result, result_valid); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic_shift;
    test_mult;
    test_div;
    test_branch_ovf;
    test_back_to_back;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
